// File: rtl/branch_redirect_unit_pkg.sv
// Shared pipeline definitions for the branch redirect path and the condition checker.
package branch_redirect_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PEND  = 2'b01,
        FLUSH = 2'b10
    } brs_state_e;

    // Branch command encodings shared with the condition checker that produces brCond.
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BNE  = 2'b01,
        BR_JUMP = 2'b10,
        BR_BEQZ = 2'b11
    } br_cmd_e;

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Bundle between the ID-stage branch logic and the PC mux / IF-ID register controls.
interface branch_redirect_unit_if
    import branch_redirect_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = 16
);
    logic              brValid;
    logic              brCond;
    logic [ADDR_W-1:0] brTarget;
    logic              freeze;
    logic              pcRedirect;
    logic [ADDR_W-1:0] redirectPC;
    logic              flushIFID;
    logic              pending;
    logic [CNT_W-1:0]  takenCount;

    modport master (
        output brValid, brCond, brTarget, freeze,
        input  pcRedirect, redirectPC, flushIFID, pending, takenCount
    );

    modport slave (
        input  brValid, brCond, brTarget, freeze,
        output pcRedirect, redirectPC, flushIFID, pending, takenCount
    );
endinterface

// File: rtl/branch_redirect_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/branch_redirect_unit.sv
// Turns a taken-branch decision into a registered PC redirect pulse plus an IF/ID flush window,
// deferring the redirect while the hazard unit freezes the pipeline.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input logic                   clk,
    input logic                   rst,
    branch_redirect_unit_if.slave bus
);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    brs_state_e        state_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic              pc_redirect_q;
    logic              flush_q;
    logic              pending_q;
    logic [2:0]        fcnt_q;
    logic              taken;
    logic              fire;

    // brValid gates brCond so an X on brCond while brValid=0 cannot reach state.
    assign taken = bus.brValid & bus.brCond;

    always_comb begin
        fire = 1'b0;
        case (state_q)
            IDLE:    fire = taken & ~bus.freeze;
            PEND:    fire = ~bus.freeze;
            default: fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            pc_redirect_q <= 1'b0;
            flush_q       <= 1'b0;
            pending_q     <= 1'b0;
            fcnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (taken) begin
                        redirect_pc_q <= bus.brTarget;
                        if (!bus.freeze) begin
                            pc_redirect_q <= 1'b1;
                            flush_q       <= 1'b1;
                            fcnt_q        <= FLUSH_LAST;
                            state_q       <= FLUSH;
                        end else begin
                            pending_q <= 1'b1;
                            state_q   <= PEND;
                        end
                    end
                end
                PEND: begin
                    // Same instruction is held in ID, so the captured target stays put.
                    if (!bus.freeze) begin
                        pending_q     <= 1'b0;
                        pc_redirect_q <= 1'b1;
                        flush_q       <= 1'b1;
                        fcnt_q        <= FLUSH_LAST;
                        state_q       <= FLUSH;
                    end
                end
                FLUSH: begin
                    pc_redirect_q <= 1'b0;
                    if (fcnt_q == '0) begin
                        flush_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        fcnt_q <= fcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_taken_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (fire),
        .count_o (bus.takenCount)
    );

    assign bus.pcRedirect = pc_redirect_q;
    assign bus.redirectPC = redirect_pc_q;
    assign bus.flushIFID  = flush_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench: default config, FLUSH_CYCLES=3 config and CNT_W=2 config driven in one sequence.
module tb_branch_redirect_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    branch_redirect_unit_if #(.ADDR_W(32), .CNT_W(16)) bA ();
    branch_redirect_unit_if #(.ADDR_W(32), .CNT_W(16)) bB ();
    branch_redirect_unit_if #(.ADDR_W(32), .CNT_W(2))  bC ();

    branch_redirect_unit #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(bA));
    branch_redirect_unit #(.ADDR_W(32), .FLUSH_CYCLES(3), .CNT_W(16)) dutB (.clk(clk), .rst(rst), .bus(bB));
    branch_redirect_unit #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(2))  dutC (.clk(clk), .rst(rst), .bus(bC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drvA(input logic v, input logic c, input logic [31:0] t, input logic f);
        bA.brValid = v; bA.brCond = c; bA.brTarget = t; bA.freeze = f;
    endtask
    task automatic drvB(input logic v, input logic c, input logic [31:0] t, input logic f);
        bB.brValid = v; bB.brCond = c; bB.brTarget = t; bB.freeze = f;
    endtask
    task automatic drvC(input logic v, input logic c, input logic [31:0] t, input logic f);
        bC.brValid = v; bC.brCond = c; bC.brTarget = t; bC.freeze = f;
    endtask

    task automatic chkA(input string tag, input logic r, input logic [31:0] pc,
                        input logic fl, input logic p, input logic [15:0] cnt);
        check({tag, ".pcRedirect"}, 64'(bA.pcRedirect), 64'(r));
        check({tag, ".redirectPC"}, 64'(bA.redirectPC), 64'(pc));
        check({tag, ".flushIFID"},  64'(bA.flushIFID),  64'(fl));
        check({tag, ".pending"},    64'(bA.pending),    64'(p));
        check({tag, ".takenCount"}, 64'(bA.takenCount), 64'(cnt));
    endtask

    task automatic chkB(input string tag, input logic r, input logic [31:0] pc,
                        input logic fl, input logic [15:0] cnt);
        check({tag, ".pcRedirect"}, 64'(bB.pcRedirect), 64'(r));
        check({tag, ".redirectPC"}, 64'(bB.redirectPC), 64'(pc));
        check({tag, ".flushIFID"},  64'(bB.flushIFID),  64'(fl));
        check({tag, ".takenCount"}, 64'(bB.takenCount), 64'(cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drvA(0, 0, 32'h0, 0);
        drvB(0, 0, 32'h0, 0);
        drvC(0, 0, 32'h0, 0);
        rst = 1'b0;
        tick(); tick();
        chkA("rst", 0, 32'h0, 0, 0, 16'd0);
        rst = 1'b1;
        tick();
        chkA("idle", 0, 32'h0, 0, 0, 16'd0);

        // FLUSH_CYCLES=3: second taken event next cycle is wrong-path
        drvB(1, 1, 32'h20, 0); tick();
        chkB("b3.e1", 1, 32'h20, 1, 16'd1);
        drvB(1, 1, 32'h60, 0); tick();
        chkB("b3.e2", 0, 32'h20, 1, 16'd1);
        drvB(0, 0, 32'h0, 0); tick();
        chkB("b3.e3", 0, 32'h20, 1, 16'd1);
        tick();
        chkB("b3.e4", 0, 32'h20, 0, 16'd1);
        tick();
        chkB("b3.e5", 0, 32'h20, 0, 16'd1);

        // CNT_W=2 saturation: 1, 2, 3, 3
        for (int unsigned i = 0; i < 4; i++) begin
            drvC(1, 1, 32'h400 + 32'(i * 4), 0); tick();
            check("sat.pcRedirect", 64'(bC.pcRedirect), 64'd1);
            check("sat.takenCount", 64'(bC.takenCount), (i < 3) ? 64'(i + 1) : 64'd3);
            drvC(0, 0, 32'h0, 0); tick(); tick();
        end

        // Basic taken branch, freeze low
        drvA(1, 1, 32'h40, 0); tick();
        chkA("tk.e1", 1, 32'h40, 1, 0, 16'd1);
        drvA(0, 0, 32'h0, 0); tick();
        chkA("tk.e2", 0, 32'h40, 0, 0, 16'd1);
        tick();

        // Not-taken, then X on brCond/brTarget with brValid low
        drvA(1, 0, 32'h80, 0); tick();
        chkA("nt", 0, 32'h40, 0, 0, 16'd1);
        bA.brValid = 1'b0; bA.brCond = 1'bx; bA.brTarget = 'x; tick();
        chkA("xin", 0, 32'h40, 0, 0, 16'd1);

        // Back-to-back with FLUSH_CYCLES=1: event on the FLUSH->IDLE edge is ignored
        drvA(1, 1, 32'h44, 0); tick();
        chkA("bb.e1", 1, 32'h44, 1, 0, 16'd2);
        drvA(1, 1, 32'h48, 0); tick();
        chkA("bb.e2", 0, 32'h44, 0, 0, 16'd2);
        tick();
        chkA("bb.e3", 1, 32'h48, 1, 0, 16'd3);
        drvA(0, 0, 32'h0, 0); tick(); tick();
        chkA("bb.e4", 0, 32'h48, 0, 0, 16'd3);

        // Freeze for 3 cycles; target changes meanwhile but the captured one holds
        drvA(1, 1, 32'h100, 1); tick();
        chkA("pd.e1", 0, 32'h100, 0, 1, 16'd3);
        drvA(1, 1, 32'h200, 1); tick();
        chkA("pd.e2", 0, 32'h100, 0, 1, 16'd3);
        tick();
        chkA("pd.e3", 0, 32'h100, 0, 1, 16'd3);
        drvA(1, 1, 32'h200, 0); tick();
        chkA("pd.rel", 1, 32'h100, 1, 0, 16'd4);
        drvA(0, 0, 32'h0, 0); tick();
        chkA("pd.done", 0, 32'h100, 0, 0, 16'd4);
        tick();

        // Reset while pending discards the branch
        drvA(1, 1, 32'h300, 1); tick();
        chkA("rp.pend", 0, 32'h300, 0, 1, 16'd4);
        #2 rst = 1'b0;
        #1;
        chkA("rp.async", 0, 32'h0, 0, 0, 16'd0);
        drvA(0, 0, 32'h0, 0);
        tick(); tick();
        rst = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            chkA("rp.after", 0, 32'h0, 0, 0, 16'd0);
        end
        check("rp.b.takenCount", 64'(bB.takenCount), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumer of the ID-stage branch-condition flag (brCond) in the pipelined MIPS datapath. Turns a taken-branch decision into a registered PC redirect plus an IF/ID flush window.
- Holds a taken branch that arrives while the hazard unit freezes the pipeline, then issues the redirect once the freeze lifts.
- Sits between the branch condition logic and the PC mux / IF/ID pipeline register. Also keeps a saturating count of taken branches for the simulator statistics.

Parameters:
- ADDR_W, 32, width of PC and target addresses
- FLUSH_CYCLES, 1, number of cycles flushIFID stays asserted per redirect (legal range 1..7)
- CNT_W, 16, width of takenCount

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- brValid  input  1  a branch/jump instruction occupies ID this cycle
- brCond  input  1  branch-condition result for that instruction (1 = taken)
- brTarget  input  ADDR_W  computed target address for that instruction
- freeze  input  1  hazard-unit stall; the PC and IF/ID are held while high
- pcRedirect  output  1  one-cycle pulse: PC mux selects redirectPC
- redirectPC  output  ADDR_W  registered target address
- flushIFID  output  1  IF/ID register loads a bubble while high
- pending  output  1  a taken branch is waiting for freeze to drop
- takenCount  output  CNT_W  number of redirects issued, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; pcRedirect=0, redirectPC=0, flushIFID=0, pending=0, takenCount=0, flush counter=0. Reset asserted mid-flush or mid-pending discards the branch, and no redirect follows after release.
- All outputs are registered. No combinational path from inputs to outputs.
- Taken event: brValid=1 and brCond=1, sampled at a rising edge while not inside a flush window. brValid=1 with brCond=0 is not-taken: no action, no count.
- States:
  - IDLE:
    - Taken event with freeze=0 → capture brTarget into redirectPC; next cycle pcRedirect=1 and flushIFID=1; go FLUSH.
    - Taken event with freeze=1 → capture brTarget; pending=1; go PEND.
  - PEND:
    - brValid/brCond/brTarget are ignored, because the same instruction is held in ID. The captured target is not overwritten.
    - On the first edge that samples freeze=0: pending=0, pcRedirect=1, flushIFID=1; go FLUSH.
  - FLUSH:
    - pcRedirect is high only in the first FLUSH cycle.
    - flushIFID stays high for exactly FLUSH_CYCLES cycles, counted from the pcRedirect cycle, then the block returns to IDLE.
    - Taken events sampled during FLUSH are ignored: those instructions are wrong-path.
    - freeze during FLUSH does not extend the window.
- Latency:
  - Taken event at edge N with freeze=0 → pcRedirect high during cycle N+1.
  - From PEND: pcRedirect high in the cycle after the edge that samples freeze=0.
- Back-to-back: with FLUSH_CYCLES=1, a taken event at the edge where FLUSH ends to IDLE is ignored. The first accepted event is sampled one edge later, in IDLE.
- takenCount increments by 1 in the cycle pcRedirect rises. It holds at all-ones (2^CNT_W−1) with no wrap.
- redirectPC holds its last captured value between branches.
- X on brCond/brTarget while brValid=0 must not propagate into state.

Decomposition:
- Shared pipeline package: state enum (IDLE, PEND, FLUSH), ADDR_W default, and the branch command encodings already used by the condition checker (00 none, 01 bne, 10 jump, 11 beqz). This gives both ends of the brCond interface one source.
- One natural sub-module: sat_counter (parameterised width, increment enable, saturate at max), used for takenCount.
- Flush-window counter stays inline.

Test Plan:
- Reset, then brValid=1, brCond=1, brTarget=0x0000_0040, freeze=0 for one cycle → next cycle pcRedirect=1, redirectPC=0x40, flushIFID=1 for 1 cycle, takenCount=1.
- brValid=1, brCond=0, brTarget=0x80 → pcRedirect, flushIFID and pending stay 0; takenCount unchanged; redirectPC keeps its prior value.
- Taken event at target 0x100 with freeze=1 for 3 cycles, brTarget changing to 0x200 meanwhile → pending=1 for 3 cycles; one cycle after freeze drops, pcRedirect=1 with redirectPC=0x100.
- FLUSH_CYCLES=3, taken event to 0x20, then a second taken event to 0x60 in the next cycle → flushIFID high for 3 cycles; the second event is ignored; exactly one redirect; takenCount=1.
- Assert rst=0 while pending=1 with target 0x300, release after 2 cycles with freeze=0 → all outputs 0; no redirect ever issued.
- CNT_W=2, four spaced taken events → takenCount sequence 1, 2, 3, 3.
